// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo: first-word-fall-through receive buffer with overrun tracking
// Revision: 1.0
// ============================================================================
module uart_rx_fifo #(
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     wr_ferr_i,
  input  logic                     flush_i,
  input  logic                     clear_overrun_i,
  output logic [WIDTH-1:0]         m_axis_tdata_o,
  output logic                     m_axis_tuser_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     overrun_flag_o,
  output logic [7:0]               overrun_cnt_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [WIDTH:0]   mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovr_flag_q, ovr_flag_d;
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;

  logic             full;
  logic             pop;
  logic             push;
  logic             overrun;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop     = (count_q != '0) && m_axis_tready_i;
  // A pop in the same cycle frees the slot a write into a full buffer needs.
  assign push    = wr_en_i && (!full || pop);
  assign overrun = wr_en_i && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovr_flag_d = ovr_flag_q;
    ovr_cnt_d  = ovr_cnt_q;

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {wr_ferr_i, wr_data_i};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // A new overrun in the clearing cycle takes priority over the clear.
    if (clear_overrun_i) begin
      ovr_flag_d = overrun;
      ovr_cnt_d  = overrun ? 8'd1 : 8'd0;
    end else if (overrun) begin
      ovr_flag_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) begin
        ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovr_flag_q <= 1'b0;
      ovr_cnt_q  <= 8'd0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovr_flag_q <= ovr_flag_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign m_axis_tdata_o  = mem_q[rd_ptr_q][WIDTH-1:0];
  assign m_axis_tuser_o  = mem_q[rd_ptr_q][WIDTH];
  assign m_axis_tvalid_o = (count_q != '0);
  assign count_o         = count_q;
  assign empty_o         = (count_q == '0);
  assign full_o          = full;
  assign almost_full_o   = (count_q >= CNT_W'(ALMOST_FULL_LEVEL));
  assign overrun_flag_o  = ovr_flag_q;
  assign overrun_cnt_o   = ovr_cnt_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each received word together with its framing-error status when the receiver pulses its FIFO write enable.
- Stores entries in a circular buffer and presents them on an AXI4-Stream style master interface (valid/ready) to the bus-side consumer.
- Reports fill level, almost-full backpressure, and sticky overrun status with a saturating drop counter.

Parameters:
- WIDTH, 8, data bits per received word.
- DEPTH, 16, number of entries; power of two, minimum 2.
- ALMOST_FULL_LEVEL, 12, count at or above which almost_full_o asserts; range 1..DEPTH.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  synchronous active-low reset.
- wr_en_i  input  1  one-cycle write strobe from the receiver.
- wr_data_i  input  WIDTH  received word, valid when wr_en_i=1.
- wr_ferr_i  input  1  framing-error tag for the word, sampled with wr_en_i.
- flush_i  input  1  synchronous buffer clear.
- clear_overrun_i  input  1  clears overrun_flag_o and overrun_cnt_o.
- m_axis_tdata_o  output  WIDTH  head-of-queue word.
- m_axis_tuser_o  output  1  framing-error tag of the head word.
- m_axis_tvalid_o  output  1  head word valid.
- m_axis_tready_i  input  1  consumer ready.
- count_o  output  $clog2(DEPTH)+1  entries held, including the head.
- empty_o  output  1  count_o==0.
- full_o  output  1  count_o==DEPTH.
- almost_full_o  output  1  count_o>=ALMOST_FULL_LEVEL; for receiver backpressure.
- overrun_flag_o  output  1  sticky: a write was dropped.
- overrun_cnt_o  output  8  saturating count of dropped writes.

Behaviour:
- Reset (reset_i=0 at a clock edge) drives:
  - all outputs to 0, except empty_o=1;
  - read and write pointers to 0;
  - m_axis_tdata_o=0 and m_axis_tuser_o=0.
  - Reset wins over every other input, including mid-transfer.
- Storage: DEPTH entries of WIDTH+1 bits ({ferr, data}). Read and write pointers wrap modulo DEPTH.
- Interface mode: first-word-fall-through. m_axis_tvalid_o = (count_o!=0). Data and user outputs always reflect the entry at the read pointer, so a write into an empty buffer shows tvalid=1 on the following cycle (1-cycle latency).
- Pop: occurs when m_axis_tvalid_o && m_axis_tready_i at a clock edge; advances the read pointer. tdata/tuser must stay stable while tvalid=1 and tready=0.
- Push accepted when wr_en_i && (!full_o || pop this cycle).
  - When full, a simultaneous pop frees a slot, so the write is accepted with no overrun.
- Count update:
  - push only: +1;
  - pop only: -1;
  - push and pop together: unchanged.
- Overrun: wr_en_i while full with no pop.
  - The word is discarded; pointers and count are unchanged.
  - overrun_flag_o <= 1.
  - overrun_cnt_o increments, saturating at 255.
- clear_overrun_i: flag <= 0 and counter <= 0. If an overrun occurs in the same cycle, the set has priority: flag=1, counter=1.
- flush_i: pointers and count <= 0 next cycle.
  - Any push or pop in the same cycle is ignored.
  - Overrun flag and counter are not affected.
- Status outputs (empty_o, full_o, almost_full_o) are combinational from registered count_o and reflect the post-edge state.
- wr_data_i and wr_ferr_i are ignored when wr_en_i=0.
- No underrun condition exists: tready with tvalid=0 has no effect.

Test Plan:
- Reset then single write: release reset, write 0xA5 with ferr=0, tready=0 -> next cycle tvalid=1, tdata=0xA5, tuser=0, count=1, empty=0; assert tready 1 cycle -> count=0, tvalid=0, empty=1.
- Fill to full: write 16 words 0x00..0x0F with tready=0.
  - almost_full rises when count reaches 12; full=1 at 16.
  - 17th write 0xFF -> overrun_flag=1, overrun_cnt=1, count stays 16.
  - Drain yields exactly 0x00..0x0F in order, with no 0xFF.
- Full with simultaneous push/pop: at full, wr_en=1 with 0x55 and tready=1 -> overrun_flag stays 0, count stays 16; 0x55 emerges last after drain.
- Framing tag and backpressure hold: write 0x3C with ferr=1, hold tready=0 for 5 cycles -> tdata=0x3C, tuser=1, stable throughout; pop clears it.
- Pointer wrap: stream 40 words with tready=1 continuously and writes every cycle -> count oscillates 0..1, every word is delivered in order, pointers wrap twice with no loss.
- Flags, flush and reset mid-operation:
  - 300 overrun writes -> overrun_cnt=255.
  - clear_overrun with a concurrent overrun -> flag=1, cnt=1.
  - flush with 7 entries -> count=0, flag unchanged.
  - reset_i=0 with 5 entries -> all outputs at reset values next cycle.
